addsel_pipe: RTL

- Parametrised, registered successor to the continuous-assign arithmetic/select idiom: per-lane `sum = b + c` and `sel = (b < THRESH) ? f : g`.
- Computed for CH independent lanes in a 2-stage valid/ready pipeline with backpressure.
- Sits between stimulus/issue logic and result consumers; replaces bare `assign` chains wherever results must be timed and flow-controlled.

---
 rtl/addsel_pkg.sv | 15 +
 rtl/addsel_lane.sv | 31 +++
 rtl/addsel_pipe.sv | 94 +++++++++
 3 files changed

// File: rtl/addsel_pkg.sv
// Shared defaults and lane result type for the addsel pipeline.
package addsel_pkg;

  localparam int unsigned WIDTH_D  = 8;
  localparam int unsigned SEL_W_D  = 32;
  localparam int unsigned CH_D     = 2;
  localparam int unsigned THRESH_D = 2;

  typedef struct packed {
    logic [WIDTH_D-1:0] sum;
    logic               carry;
    logic [SEL_W_D-1:0] sel;
  } lane_res_t;

endpackage

// File: rtl/addsel_lane.sv
// Combinational single-lane stage-2 function: add with carry and select.
// ADDSEL_SAT_EN: saturate the sum to all-ones when the add carries out.
module addsel_lane
  import addsel_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_D,
  parameter int unsigned SEL_W = SEL_W_D
) (
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             lt,
  input  logic [SEL_W-1:0] f,
  input  logic [SEL_W-1:0] g,
  output logic [WIDTH-1:0] sum_c,
  output logic             carry_c,
  output logic [SEL_W-1:0] sel_c
);

  logic [WIDTH:0] full;

  assign full    = {1'b0, b} + {1'b0, c};
  assign carry_c = full[WIDTH];
  assign sel_c   = lt ? f : g;

`ifdef ADDSEL_SAT_EN
  assign sum_c = full[WIDTH] ? '1 : full[WIDTH-1:0];
`else
  assign sum_c = full[WIDTH-1:0];
`endif

endmodule

// File: rtl/addsel_pipe.sv
// Two-stage valid/ready pipeline computing per-lane b+c and a threshold select.
// ADDSEL_SAT_EN (in addsel_lane) switches the sum from modular wrap to saturation.
module addsel_pipe
  import addsel_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_D,
  parameter int unsigned SEL_W  = SEL_W_D,
  parameter int unsigned CH     = CH_D,
  parameter int unsigned THRESH = THRESH_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] in_b,
  input  logic [CH*WIDTH-1:0] in_c,
  input  logic [CH*SEL_W-1:0] in_f,
  input  logic [CH*SEL_W-1:0] in_g,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CH*WIDTH-1:0] out_sum,
  output logic [CH-1:0]       out_carry,
  output logic [CH*SEL_W-1:0] out_sel
);

  localparam logic [WIDTH-1:0] THR = WIDTH'(THRESH);

  logic                v1, v2, adv1, adv2;
  logic [CH*WIDTH-1:0] s1_b, s1_c;
  logic [CH*SEL_W-1:0] s1_f, s1_g;
  logic [CH-1:0]       s1_lt, lt_c;
  logic [CH*WIDTH-1:0] sum_c;
  logic [CH-1:0]       carry_c;
  logic [CH*SEL_W-1:0] sel_c;

  // Combinational ready chain: a stage moves when its successor frees up.
  assign adv2      = out_ready | ~v2;
  assign adv1      = adv2 | ~v1;
  assign in_ready  = adv1;
  assign out_valid = v2;

  for (genvar i = 0; i < CH; i++) begin : g_lane
    assign lt_c[i] = in_b[i*WIDTH +: WIDTH] < THR;

    addsel_lane #(
      .WIDTH (WIDTH),
      .SEL_W (SEL_W)
    ) u_lane (
      .b       (s1_b[i*WIDTH +: WIDTH]),
      .c       (s1_c[i*WIDTH +: WIDTH]),
      .lt      (s1_lt[i]),
      .f       (s1_f[i*SEL_W +: SEL_W]),
      .g       (s1_g[i*SEL_W +: SEL_W]),
      .sum_c   (sum_c[i*WIDTH +: WIDTH]),
      .carry_c (carry_c[i]),
      .sel_c   (sel_c[i*SEL_W +: SEL_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1_b      <= '0;
      s1_c      <= '0;
      s1_f      <= '0;
      s1_g      <= '0;
      s1_lt     <= '0;
      out_sum   <= '0;
      out_carry <= '0;
      out_sel   <= '0;
    end else begin
      if (adv1) begin
        v1 <= in_valid;
        if (in_valid) begin
          s1_b  <= in_b;
          s1_c  <= in_c;
          s1_f  <= in_f;
          s1_g  <= in_g;
          s1_lt <= lt_c;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          out_sum   <= sum_c;
          out_carry <= carry_c;
          out_sel   <= sel_c;
        end
      end
    end
  end

endmodule
